// File: rtl/mem_access_sequencer.sv
// Load/store sequencer: splits word-crossing accesses into two beats on a single-outstanding req/gnt/rvalid bus.
// Latency: accept T0, bus_req T1, completion pulse one cycle after the last rvalid (T3 minimum aligned, +2 split).
// Backpressure: ex_ready only in IDLE/DONE; stall holds the pipeline while an offered op cannot be accepted.
module mem_access_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] ex_addr,
    input  logic [1:0]      ex_width,
    input  logic            ex_sign_extend,
    input  logic            ex_w_enable,
    input  logic [XLEN-1:0] ex_w_value,
    input  logic [4:0]      ex_rd,
    output logic            stall,
    output logic            bus_req,
    output logic [XLEN-1:0] bus_addr,
    output logic            bus_we,
    output logic [3:0]      bus_be,
    output logic [XLEN-1:0] bus_wdata,
    input  logic            bus_gnt,
    input  logic            bus_rvalid,
    input  logic [XLEN-1:0] bus_rdata,
    input  logic            bus_err,
    output logic            wb_valid,
    output logic            wb_reg_enable,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_value,
    output logic            wb_fault
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_LO  = 3'd1,
        WAIT_LO = 3'd2,
        REQ_HI  = 3'd3,
        WAIT_HI = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [1:0] W_BYTE = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;

    state_t state;

    // Captured op: everything needed for the second beat and for read assembly.
    logic            op_split;
    logic [1:0]      op_off;
    logic [1:0]      op_width;
    logic            op_sext;
    logic            op_we;
    logic [4:0]      op_rd;
    logic [XLEN-1:0] op_hi_addr;
    logic [3:0]      op_hi_be;
    logic [XLEN-1:0] op_hi_wdata;
    logic [XLEN-1:0] lo_rdata;

    logic [2:0]      acc_size;
    logic [3:0]      acc_mask;
    logic [1:0]      acc_off;
    logic            acc_split;
    logic [7:0]      acc_be64;
    logic [63:0]     acc_lane_mask;
    logic [63:0]     acc_wd64;
    logic [XLEN-1:0] acc_lo_addr;
    logic [XLEN-1:0] acc_hi_addr;

    logic            accept;
    logic            rsp_done;
    logic [XLEN-1:0] rsp_lo;
    logic [XLEN-1:0] rsp_hi;
    logic [XLEN-1:0] load_value;

    function automatic logic [XLEN-1:0] assemble(
        input logic [XLEN-1:0] lo,
        input logic [XLEN-1:0] hi,
        input logic [1:0]      off,
        input logic [1:0]      width,
        input logic            sext
    );
        logic [XLEN-1:0] r;
        r = XLEN'({hi, lo} >> {off, 3'b000});
        case (width)
            W_BYTE:  assemble = sext ? {{24{r[7]}}, r[7:0]}   : {24'h0, r[7:0]};
            W_HALF:  assemble = sext ? {{16{r[15]}}, r[15:0]} : {16'h0, r[15:0]};
            default: assemble = r;
        endcase
    endfunction

    always_comb begin
        acc_off = ex_addr[1:0];
        case (ex_width)
            W_BYTE:  begin acc_size = 3'd1; acc_mask = 4'b0001; end
            W_HALF:  begin acc_size = 3'd2; acc_mask = 4'b0011; end
            default: begin acc_size = 3'd4; acc_mask = 4'b1111; end
        endcase
        acc_split = ({1'b0, acc_off} + acc_size) > 3'd4;
        acc_be64  = {4'b0000, acc_mask} << acc_off;
        acc_lane_mask = '0;
        for (int i = 0; i < 8; i++) begin
            acc_lane_mask[8*i +: 8] = {8{acc_be64[i]}};
        end
        // Bytes outside the enables are zeroed rather than left as shifted garbage.
        acc_wd64    = ({32'h0, ex_w_value} << {acc_off, 3'b000}) & acc_lane_mask;
        acc_lo_addr = {ex_addr[XLEN-1:2], 2'b00};
        acc_hi_addr = acc_lo_addr + XLEN'(4);
    end

    assign ex_ready = (state == IDLE) || (state == DONE);
    assign stall    = ex_valid && !ex_ready;
    assign accept   = ex_valid && ex_ready;

    always_comb begin
        rsp_lo   = (state == WAIT_HI) ? lo_rdata  : bus_rdata;
        rsp_hi   = (state == WAIT_HI) ? bus_rdata : '0;
        rsp_done = bus_rvalid &&
                   (((state == WAIT_LO) && (bus_err || !op_split)) || (state == WAIT_HI));
        load_value = assemble(rsp_lo, rsp_hi, op_off, op_width, op_sext);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            bus_req       <= 1'b0;
            bus_addr      <= '0;
            bus_we        <= 1'b0;
            bus_be        <= '0;
            bus_wdata     <= '0;
            wb_valid      <= 1'b0;
            wb_reg_enable <= 1'b0;
            wb_rd         <= '0;
            wb_value      <= '0;
            wb_fault      <= 1'b0;
            op_split      <= 1'b0;
            op_off        <= '0;
            op_width      <= '0;
            op_sext       <= 1'b0;
            op_we         <= 1'b0;
            op_rd         <= '0;
            op_hi_addr    <= '0;
            op_hi_be      <= '0;
            op_hi_wdata   <= '0;
            lo_rdata      <= '0;
        end else begin
            wb_valid      <= 1'b0;
            wb_reg_enable <= 1'b0;

            if (rsp_done) begin
                wb_valid      <= 1'b1;
                wb_rd         <= op_rd;
                wb_fault      <= bus_err;
                wb_value      <= (bus_err || op_we) ? '0 : load_value;
                wb_reg_enable <= !op_we && !bus_err;
            end

            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state       <= REQ_LO;
                        bus_req     <= 1'b1;
                        bus_addr    <= acc_lo_addr;
                        bus_we      <= ex_w_enable;
                        bus_be      <= acc_be64[3:0];
                        bus_wdata   <= acc_wd64[31:0];
                        op_split    <= acc_split;
                        op_off      <= acc_off;
                        op_width    <= ex_width;
                        op_sext     <= ex_sign_extend;
                        op_we       <= ex_w_enable;
                        op_rd       <= ex_rd;
                        op_hi_addr  <= acc_hi_addr;
                        op_hi_be    <= acc_be64[7:4];
                        op_hi_wdata <= acc_wd64[63:32];
                    end else begin
                        state <= IDLE;
                    end
                end
                REQ_LO: begin
                    if (bus_gnt) begin
                        bus_req <= 1'b0;
                        state   <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (rsp_done) begin
                        state <= DONE;
                    end else if (bus_rvalid) begin
                        lo_rdata  <= bus_rdata;
                        bus_req   <= 1'b1;
                        bus_addr  <= op_hi_addr;
                        bus_be    <= op_hi_be;
                        bus_wdata <= op_hi_wdata;
                        state     <= REQ_HI;
                    end
                end
                REQ_HI: begin
                    if (bus_gnt) begin
                        bus_req <= 1'b0;
                        state   <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (rsp_done) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: directed ops against a behavioural bus slave, writeback scoreboard.
module tb_mem_access_sequencer;

    localparam logic [1:0] W_BYTE = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;
    localparam logic [1:0] W_WORD = 2'd2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_addr;
    logic [1:0]  ex_width;
    logic        ex_sign_extend;
    logic        ex_w_enable;
    logic [31:0] ex_w_value;
    logic [4:0]  ex_rd;
    logic        stall;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;
    logic        wb_valid;
    logic        wb_reg_enable;
    logic [4:0]  wb_rd;
    logic [31:0] wb_value;
    logic        wb_fault;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] value;
        logic        chk_value;
        logic        reg_en;
        logic        fault;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    int errors   = 0;
    int checks   = 0;
    int wb_count = 0;

    always #5 clk = ~clk;

    mem_access_sequencer #(.XLEN(32)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_addr       (ex_addr),
        .ex_width      (ex_width),
        .ex_sign_extend(ex_sign_extend),
        .ex_w_enable   (ex_w_enable),
        .ex_w_value    (ex_w_value),
        .ex_rd         (ex_rd),
        .stall         (stall),
        .bus_req       (bus_req),
        .bus_addr      (bus_addr),
        .bus_we        (bus_we),
        .bus_be        (bus_be),
        .bus_wdata     (bus_wdata),
        .bus_gnt       (bus_gnt),
        .bus_rvalid    (bus_rvalid),
        .bus_rdata     (bus_rdata),
        .bus_err       (bus_err),
        .wb_valid      (wb_valid),
        .wb_reg_enable (wb_reg_enable),
        .wb_rd         (wb_rd),
        .wb_value      (wb_value),
        .wb_fault      (wb_fault)
    );

    // Scoreboard: every completion pulse pops and checks the oldest expectation.
    task automatic wb_monitor();
        wb_exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && wb_valid === 1'b1) begin
                wb_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wb_unexpected: rd=%0d value=%h with no op outstanding", wb_rd, wb_value);
                end else begin
                    e = exp_q.pop_front();
                    if (wb_rd !== e.rd || wb_reg_enable !== e.reg_en || wb_fault !== e.fault ||
                        (e.chk_value && wb_value !== e.value)) begin
                        errors++;
                        $display("FAIL wb_result: got rd=%0d val=%h en=%b fault=%b, required rd=%0d val=%h en=%b fault=%b",
                                 wb_rd, wb_value, wb_reg_enable, wb_fault, e.rd, e.value, e.reg_en, e.fault);
                    end
                end
            end
        end
    endtask

    // Offers an op starting at a negedge; returns at the negedge after acceptance.
    task automatic drive_op(input logic [31:0] addr, input logic [1:0] width, input logic sext,
                            input logic we, input logic [31:0] wval, input logic [4:0] rd);
        ex_addr = addr; ex_width = width; ex_sign_extend = sext;
        ex_w_enable = we; ex_w_value = wval; ex_rd = rd; ex_valid = 1'b1;
        for (int i = 0; i < 20 && ex_ready !== 1'b1; i++) @(negedge clk);
        checks++;
        if (ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: ex_ready=%b required 1", ex_ready);
        end
        @(negedge clk);
        ex_valid = 1'b0;
    endtask

    // Slave for one beat: waits for req, withholds gnt, then optionally answers the cycle after gnt.
    task automatic serve_beat(input int gnt_delay, input logic [31:0] rdata, input logic err,
                              input logic respond, output logic [31:0] addr, output logic [3:0] be,
                              output logic [31:0] wdata, output logic we, output logic stable,
                              output logic seen);
        stable = 1'b1;
        for (int i = 0; i < 20 && bus_req !== 1'b1; i++) @(negedge clk);
        seen = (bus_req === 1'b1);
        addr = bus_addr; be = bus_be; wdata = bus_wdata; we = bus_we;
        if (!seen) return;
        for (int i = 0; i < gnt_delay; i++) begin
            @(negedge clk);
            if (bus_req !== 1'b1 || bus_addr !== addr || bus_be !== be ||
                bus_wdata !== wdata || bus_we !== we) stable = 1'b0;
        end
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        if (respond) begin
            bus_rvalid = 1'b1; bus_rdata = rdata; bus_err = err;
            @(negedge clk);
            bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus_req !== 0 || bus_we !== 0 || bus_addr !== 0 || bus_be !== 0 || bus_wdata !== 0) begin
            errors++;
            $display("FAIL reset_bus: req=%b we=%b addr=%h be=%b wdata=%h required all 0",
                     bus_req, bus_we, bus_addr, bus_be, bus_wdata);
        end
        checks++;
        if (wb_valid !== 0 || wb_reg_enable !== 0 || wb_fault !== 0 || wb_rd !== 0 || wb_value !== 0) begin
            errors++;
            $display("FAIL reset_wb: valid=%b en=%b fault=%b rd=%0d value=%h required all 0",
                     wb_valid, wb_reg_enable, wb_fault, wb_rd, wb_value);
        end
        checks++;
        if (stall !== 0 || ex_ready !== 1) begin
            errors++;
            $display("FAIL reset_handshake: stall=%b ex_ready=%b required 0/1", stall, ex_ready);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_aligned_lw();
        logic [31:0] a, w; logic [3:0] be; logic we, st, seen;
        exp_q.push_back('{rd: 5'd5, value: 32'hDEADBEEF, chk_value: 1'b1, reg_en: 1'b1, fault: 1'b0});
        drive_op(32'h100, W_WORD, 1'b0, 1'b0, 32'h0, 5'd5);
        serve_beat(0, 32'hDEADBEEF, 1'b0, 1'b1, a, be, w, we, st, seen);
        checks++;
        if (!seen || a !== 32'h100 || be !== 4'b1111 || we !== 1'b0) begin
            errors++;
            $display("FAIL lw_beat: seen=%b addr=%h be=%b we=%b required 1/00000100/1111/0", seen, a, be, we);
        end
        checks++;
        if (wb_valid !== 1'b1) begin
            errors++;
            $display("FAIL lw_latency: wb_valid=%b at T3 required 1", wb_valid);
        end
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL lw_pulse_width: wb_valid=%b one cycle later required 0", wb_valid);
        end
    endtask

    task automatic test_byte_loads();
        logic [31:0] a, w; logic [3:0] be; logic we, st, seen;
        exp_q.push_back('{rd: 5'd7, value: 32'hFFFFFF80, chk_value: 1'b1, reg_en: 1'b1, fault: 1'b0});
        drive_op(32'h203, W_BYTE, 1'b1, 1'b0, 32'h0, 5'd7);
        serve_beat(0, 32'h80000000, 1'b0, 1'b1, a, be, w, we, st, seen);
        checks++;
        if (!seen || a !== 32'h200 || be !== 4'b1000) begin
            errors++;
            $display("FAIL lb_beat: seen=%b addr=%h be=%b required 1/00000200/1000", seen, a, be);
        end
        @(negedge clk);
        exp_q.push_back('{rd: 5'd8, value: 32'h00000080, chk_value: 1'b1, reg_en: 1'b1, fault: 1'b0});
        drive_op(32'h203, W_BYTE, 1'b0, 1'b0, 32'h0, 5'd8);
        serve_beat(0, 32'h80000000, 1'b0, 1'b1, a, be, w, we, st, seen);
        checks++;
        if (!seen || be !== 4'b1000) begin
            errors++;
            $display("FAIL lbu_beat: seen=%b be=%b required 1/1000", seen, be);
        end
        @(negedge clk);
    endtask

    task automatic test_split_store();
        logic [31:0] a, w; logic [3:0] be; logic we, st, seen;
        int c0;
        c0 = wb_count;
        exp_q.push_back('{rd: 5'd3, value: 32'h0, chk_value: 1'b0, reg_en: 1'b0, fault: 1'b0});
        drive_op(32'h302, W_WORD, 1'b0, 1'b1, 32'h11223344, 5'd3);
        serve_beat(0, 32'h0, 1'b0, 1'b1, a, be, w, we, st, seen);
        checks++;
        if (!seen || a !== 32'h300 || be !== 4'b1100 || w !== 32'h33440000 || we !== 1'b1) begin
            errors++;
            $display("FAIL sw_lo_beat: addr=%h be=%b wdata=%h we=%b required 00000300/1100/33440000/1",
                     a, be, w, we);
        end
        serve_beat(0, 32'h0, 1'b0, 1'b1, a, be, w, we, st, seen);
        checks++;
        if (!seen || a !== 32'h304 || be !== 4'b0011 || w !== 32'h00001122 || we !== 1'b1) begin
            errors++;
            $display("FAIL sw_hi_beat: seen=%b addr=%h be=%b wdata=%h we=%b required 1/00000304/0011/00001122/1",
                     seen, a, be, w, we);
        end
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0 || wb_count - c0 != 1) begin
            errors++;
            $display("FAIL sw_single_pulse: pulses=%0d wb_valid=%b required 1/0", wb_count - c0, wb_valid);
        end
    endtask

    task automatic test_split_wrap();
        logic [31:0] a, w; logic [3:0] be; logic we, st, seen;
        exp_q.push_back('{rd: 5'd9, value: 32'hFFFFCDAB, chk_value: 1'b1, reg_en: 1'b1, fault: 1'b0});
        drive_op(32'hFFFFFFFF, W_HALF, 1'b1, 1'b0, 32'h0, 5'd9);
        serve_beat(0, 32'hAB000000, 1'b0, 1'b1, a, be, w, we, st, seen);
        checks++;
        if (!seen || a !== 32'hFFFFFFFC || be !== 4'b1000) begin
            errors++;
            $display("FAIL lh_lo_beat: addr=%h be=%b required fffffffc/1000", a, be);
        end
        serve_beat(0, 32'h000000CD, 1'b0, 1'b1, a, be, w, we, st, seen);
        checks++;
        if (!seen || a !== 32'h00000000 || be !== 4'b0001) begin
            errors++;
            $display("FAIL lh_hi_wrap: seen=%b addr=%h be=%b required 1/00000000/0001", seen, a, be);
        end
        @(negedge clk);
    endtask

    task automatic test_stall_error();
        logic [31:0] a, w; logic [3:0] be; logic we, st, seen;
        exp_q.push_back('{rd: 5'd10, value: 32'h0, chk_value: 1'b1, reg_en: 1'b0, fault: 1'b1});
        exp_q.push_back('{rd: 5'd11, value: 32'h12345678, chk_value: 1'b1, reg_en: 1'b1, fault: 1'b0});
        drive_op(32'h401, W_WORD, 1'b0, 1'b0, 32'h0, 5'd10);
        ex_addr = 32'h500; ex_width = W_WORD; ex_sign_extend = 1'b0;
        ex_w_enable = 1'b0; ex_w_value = 32'h0; ex_rd = 5'd11; ex_valid = 1'b1;
        fork
            serve_beat(3, 32'h0, 1'b1, 1'b1, a, be, w, we, st, seen);
            begin
                for (int k = 0; k < 5; k++) begin
                    checks++;
                    if (stall !== 1'b1) begin
                        errors++;
                        $display("FAIL busy_stall: cycle %0d stall=%b required 1", k, stall);
                    end
                    @(negedge clk);
                end
            end
        join
        checks++;
        if (!seen || !st || a !== 32'h400 || be !== 4'b1110) begin
            errors++;
            $display("FAIL err_lo_beat: seen=%b stable=%b addr=%h be=%b required 1/1/00000400/1110",
                     seen, st, a, be);
        end
        checks++;
        if (stall !== 1'b0 || bus_req !== 1'b0 || wb_valid !== 1'b1) begin
            errors++;
            $display("FAIL err_done: stall=%b bus_req=%b wb_valid=%b required 0/0/1", stall, bus_req, wb_valid);
        end
        @(negedge clk);
        ex_valid = 1'b0;
        checks++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h500) begin
            errors++;
            $display("FAIL back_to_back: bus_req=%b addr=%h required 1/00000500", bus_req, bus_addr);
        end
        serve_beat(0, 32'h12345678, 1'b0, 1'b1, a, be, w, we, st, seen);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, w; logic [3:0] be; logic we, st, seen, seen_lo;
        drive_op(32'h402, W_WORD, 1'b0, 1'b0, 32'h0, 5'd12);
        serve_beat(0, 32'h55667788, 1'b0, 1'b1, a, be, w, we, st, seen_lo);
        serve_beat(0, 32'h0, 1'b0, 1'b0, a, be, w, we, st, seen);
        checks++;
        if (!seen_lo || !seen || a !== 32'h404) begin
            errors++;
            $display("FAIL rst_setup: lo=%b hi=%b hi_addr=%h required 1/1/00000404", seen_lo, seen, a);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (bus_req !== 0 || bus_addr !== 0 || bus_we !== 0 || bus_be !== 0 || bus_wdata !== 0 ||
            wb_valid !== 0 || wb_reg_enable !== 0 || wb_rd !== 0 || wb_value !== 0 || wb_fault !== 0 ||
            stall !== 0) begin
            errors++;
            $display("FAIL rst_async: req=%b addr=%h be=%b wb_valid=%b wb_rd=%0d wb_value=%h stall=%b required all 0",
                     bus_req, bus_addr, bus_be, wb_valid, wb_rd, wb_value, stall);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
        @(negedge clk);
        bus_rvalid = 1'b0; bus_rdata = '0;
        checks++;
        if (wb_valid !== 1'b0 || ex_ready !== 1'b1 || bus_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_late_rvalid: wb_valid=%b ex_ready=%b bus_req=%b required 0/1/0",
                     wb_valid, ex_ready, bus_req);
        end
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_wb: wb_valid=%b required 0", wb_valid);
        end
    endtask

    initial begin
        reset_n = 1'b0; ex_valid = 1'b0; ex_addr = '0; ex_width = '0; ex_sign_extend = 1'b0;
        ex_w_enable = 1'b0; ex_w_value = '0; ex_rd = '0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;
        fork
            wb_monitor();
        join_none
        @(negedge clk);
        test_reset();
        test_aligned_lw();
        test_byte_loads();
        test_split_store();
        test_split_wrap();
        test_stall_error();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL wb_missing: %0d completions outstanding, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
